// File: rtl/frame_buffer_writer.sv
// frame_buffer_writer: turns strobed 12-bit pixels into sequential BRAM
// writes in raster order. It tracks x/y position, flags frame completion,
// and abandons a partial frame when the pixel stream stalls.
module frame_buffer_writer #(
  parameter int IMG_WIDTH      = 320,
  parameter int IMG_HEIGHT     = 240,
  parameter int ADDR_WIDTH     = 17,
  parameter int TIMEOUT_CYCLES = 10_000_000,
  localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1,
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1
) (
  input  logic                  clk_100MHz,
  input  logic                  reset,
  input  logic                  start,
  input  logic [11:0]           pixel_data,
  input  logic                  pixel_compiled,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [11:0]           bram_din,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  frame_valid,
  output logic                  timeout_err,
  output logic [XW-1:0]         cur_x,
  output logic [YW-1:0]         cur_y
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IMG_WIDTH * IMG_HEIGHT - 1);
  localparam logic [XW-1:0]         LAST_X    = XW'(IMG_WIDTH - 1);
  localparam logic [TW-1:0]         LAST_CNT  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, CAPTURE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic [TW-1:0]         cnt_q, cnt_d;
  logic                  started_q, started_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [11:0]           din_q, din_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  valid_q, valid_d;
  logic                  terr_q, terr_d;

  // Next-state logic: start always wins over a coincident pixel strobe.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    x_d       = x_q;
    y_d       = y_q;
    cnt_d     = cnt_q;
    started_d = started_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    din_d     = din_q;
    done_d    = 1'b0;
    valid_d   = valid_q;
    terr_d    = 1'b0;

    if (start) begin
      state_d   = CAPTURE;
      addr_d    = '0;
      x_d       = '0;
      y_d       = '0;
      cnt_d     = '0;
      started_d = 1'b0;
      valid_d   = 1'b0;
    end else if (state_q == CAPTURE) begin
      if (pixel_compiled) begin
        we_d      = 1'b1;
        waddr_d   = addr_q;
        din_d     = pixel_data;
        started_d = 1'b1;
        cnt_d     = '0;
        if (addr_q == LAST_ADDR) begin
          // Final pixel: report the frame and park position at the origin.
          done_d    = 1'b1;
          valid_d   = 1'b1;
          state_d   = IDLE;
          addr_d    = '0;
          x_d       = '0;
          y_d       = '0;
          started_d = 1'b0;
        end else begin
          addr_d = addr_q + 1'b1;
          if (x_q == LAST_X) begin
            x_d = '0;
            y_d = y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end else if (started_q) begin
        // Stall watchdog only runs once the frame has begun.
        if (cnt_q == LAST_CNT) begin
          terr_d    = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
          started_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    busy_d = (state_d == CAPTURE);
  end

  // State and registered outputs; synchronous reset clears everything.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      cnt_q     <= '0;
      started_q <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      din_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      x_q       <= x_d;
      y_q       <= y_d;
      cnt_q     <= cnt_d;
      started_q <= started_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      din_q     <= din_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      valid_q   <= valid_d;
      terr_q    <= terr_d;
    end
  end

  assign bram_we     = we_q;
  assign bram_addr   = waddr_q;
  assign bram_din    = din_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign frame_valid = valid_q;
  assign timeout_err = terr_q;
  assign cur_x       = x_q;
  assign cur_y       = y_q;

endmodule
